// File: rtl/byte_strip_nlane_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_strip_nlane_pkg
// Description : Shared constants, state encoding and helper functions for the
//               N-lane byte striper.
//               Contents:
//                 c_DATA_W / c_LANE_W / c_VALID_BIT - default lane word layout
//                 c_PAD_SYMBOL / c_COM_SYMBOL       - K28.5 comma payload (BC)
//                 state_t                           - fill / emit phase
//                 clog2()                           - lane pointer width
// Revision    : 1.0 - initial release
// ============================================================================
package byte_strip_nlane_pkg;

    // Default lane word layout: {valid, payload}.
    localparam int c_DATA_W    = 8;
    localparam int c_LANE_W    = c_DATA_W + 1;
    localparam int c_VALID_BIT = c_DATA_W;

    // Payload placed on lanes that a flushed partial group left unfilled.
    localparam logic [7:0] c_PAD_SYMBOL = 8'hBC;
    localparam logic [7:0] c_COM_SYMBOL = 8'hBC;

    // ST_EMIT marks the single cycle in which a freshly loaded group is
    // presented. Filling of the next group carries on underneath it.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1 so a pointer is never zero bits wide.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_strip_nlane_if.sv
`default_nettype none
// ============================================================================
// Module      : byte_strip_nlane_if
// Description : Bus bundle between the input stage, the striper and the
//               lane serialisers.
//               data_in       - {valid, payload} byte from the input stage
//               lanes_out     - flat bus of NUM_LANES {valid, payload} words
//               group_valid   - one-cycle strobe, lanes_out updated
//               group_partial - the emitted group was a flushed partial one
//               lane_ptr      - next lane to be filled
//               group_count   - number of groups emitted (wrapping)
//               Modports: master = producer/observer side, slave = striper.
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_strip_nlane_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16
);
    import byte_strip_nlane_pkg::*;

    localparam int c_PTR_W = clog2(NUM_LANES);

    logic [DATA_W:0]                  data_in;
    logic [NUM_LANES*(DATA_W+1)-1:0]  lanes_out;
    logic                             group_valid;
    logic                             group_partial;
    logic [c_PTR_W-1:0]               lane_ptr;
    logic [CNT_W-1:0]                 group_count;

    modport master (
        output data_in,
        input  lanes_out,
        input  group_valid,
        input  group_partial,
        input  lane_ptr,
        input  group_count
    );

    modport slave (
        input  data_in,
        output lanes_out,
        output group_valid,
        output group_partial,
        output lane_ptr,
        output group_count
    );

endinterface
`default_nettype wire

// File: rtl/byte_strip_nlane_lane_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : lane_stage_reg
// Description : One staging slot of the striper.
//               clk2f       - clock
//               reset_L     - synchronous active-low reset
//               i_wr_en     - capture i_din into the slot
//               i_clr       - return the slot to all-invalid (wins over write)
//               i_pad_sel   - present {0, PAD_BYTE} instead of the slot
//               i_din       - {valid, payload} word to store
//               o_emit_word - word this lane contributes to an emit in the
//                             current cycle (includes a same-cycle write)
// Revision    : 1.0 - initial release
// ============================================================================
module lane_stage_reg
    import byte_strip_nlane_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAD_BYTE = DATA_W'(c_PAD_SYMBOL)
) (
    input  wire logic              clk2f,
    input  wire logic              reset_L,
    input  wire logic              i_wr_en,
    input  wire logic              i_clr,
    input  wire logic              i_pad_sel,
    input  wire logic [DATA_W:0]   i_din,
    output logic      [DATA_W:0]   o_emit_word
);

    logic [DATA_W:0] r_word;
    logic [DATA_W:0] w_next_word;

    // The byte completing a full group is written in the same cycle the group
    // is captured, so the emit path bypasses the register.
    assign w_next_word = i_wr_en ? i_din : r_word;
    assign o_emit_word = i_pad_sel ? {1'b0, PAD_BYTE} : w_next_word;

    always_ff @(posedge clk2f) begin
        if (!reset_L) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_wr_en) begin
            r_word <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_strip_nlane.sv
`default_nettype none
// ============================================================================
// Module      : byte_strip_nlane
// Description : Collects valid bytes from one stream and stripes them
//               round-robin over NUM_LANES lanes. A completed group (or, with
//               FLUSH_ON_IDLE, a partial group closed by an idle byte) is
//               loaded into the output register and flagged by group_valid
//               for one cycle.
//               clk2f   - clock, all logic on its rising edge
//               reset_L - synchronous active-low reset
//               bus     - slave side of byte_strip_nlane_if (data_in,
//                         lanes_out, group_valid, group_partial, lane_ptr,
//                         group_count)
// Revision    : 1.0 - initial release
// ============================================================================
module byte_strip_nlane
    import byte_strip_nlane_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                NUM_LANES     = 4,
    parameter bit                FLUSH_ON_IDLE = 1'b1,
    parameter logic [DATA_W-1:0] PAD_BYTE      = DATA_W'(c_PAD_SYMBOL),
    parameter int                CNT_W         = 16
) (
    input  wire logic          clk2f,
    input  wire logic          reset_L,
    byte_strip_nlane_if.slave  bus
);

    localparam int                 c_LANE_W    = DATA_W + 1;
    localparam int                 c_VALID_IDX = DATA_W;
    localparam int                 c_PTR_W     = clog2(NUM_LANES);
    localparam logic [c_PTR_W-1:0] c_LAST_LANE = c_PTR_W'(NUM_LANES - 1);

    // ---------------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------------
    state_t                          r_state;
    logic [c_PTR_W-1:0]              r_lane_ptr;
    logic [NUM_LANES*c_LANE_W-1:0]   r_lanes_out;
    logic                            r_partial;
    logic [CNT_W-1:0]                r_count;

    // ---------------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------------
    state_t                          w_state_next;
    logic [c_PTR_W-1:0]              w_ptr_next;
    logic                            w_in_valid;
    logic                            w_full_emit;
    logic                            w_flush;
    logic                            w_emit;
    logic [NUM_LANES-1:0]            w_wr_en;
    logic [NUM_LANES-1:0]            w_pad_sel;
    logic [NUM_LANES*c_LANE_W-1:0]   w_emit_flat;

    assign w_in_valid  = bus.data_in[c_VALID_IDX];
    assign w_full_emit = w_in_valid && (r_lane_ptr == c_LAST_LANE);
    // An idle byte only closes a group that has something in it.
    assign w_flush     = !w_in_valid && FLUSH_ON_IDLE && (r_lane_ptr != '0);
    assign w_emit      = w_full_emit || w_flush;

    // ---------------------------------------------------------------------
    // Staging slots
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(k);

        assign w_wr_en[k]   = w_in_valid && (r_lane_ptr == c_IDX);
        // Lanes at or beyond the pointer were never filled in this group.
        assign w_pad_sel[k] = w_flush && (c_IDX >= r_lane_ptr);

        lane_stage_reg #(
            .DATA_W   (DATA_W),
            .PAD_BYTE (PAD_BYTE)
        ) u_lane_stage_reg (
            .clk2f       (clk2f),
            .reset_L     (reset_L),
            .i_wr_en     (w_wr_en[k]),
            .i_clr       (w_emit),
            .i_pad_sel   (w_pad_sel[k]),
            .i_din       (bus.data_in),
            .o_emit_word (w_emit_flat[k*c_LANE_W +: c_LANE_W])
        );
    end

    // ---------------------------------------------------------------------
    // Fill / emit control
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = ST_FILL;
        w_ptr_next   = r_lane_ptr;
        if (w_emit) begin
            // A byte arriving while the group is shown lands in lane 0, so
            // the emit never stalls filling.
            w_state_next = ST_EMIT;
            w_ptr_next   = '0;
        end else if (w_in_valid) begin
            w_ptr_next   = r_lane_ptr + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk2f) begin
        if (!reset_L) begin
            r_state     <= ST_FILL;
            r_lane_ptr  <= '0;
            r_lanes_out <= '0;
            r_partial   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lane_ptr <= w_ptr_next;
            r_partial  <= w_flush;
            if (w_emit) begin
                r_lanes_out <= w_emit_flat;
                r_count     <= r_count + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.lanes_out     = r_lanes_out;
    assign bus.group_valid   = (r_state == ST_EMIT);
    assign bus.group_partial = r_partial;
    assign bus.lane_ptr      = r_lane_ptr;
    assign bus.group_count   = r_count;

endmodule
`default_nettype wire
